// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial WIDTH-bit signed add/sub with valid/ready on both sides.
// Optional ADDSUB_SEQ_SAT_EN: saturate sum on signed overflow.
module addsub_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             ovfl,
   output logic             busy
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] a_r, b_r;
   logic             carry_r;
   logic [CW-1:0]    cnt;
   logic [3:0]       nib_a, nib_b, nib_s;
   logic             nib_c, c_into_msb, ovfl_nx, last, accept;

   assign accept = in_valid & in_ready & ~flush;
   assign last   = (cnt == CW'(NIB - 1));

   // single shared 4-bit slice; b_r already holds ~B for subtraction
   always_comb begin
      nib_a          = a_r[{cnt, 2'b00} +: 4];
      nib_b          = b_r[{cnt, 2'b00} +: 4];
      {nib_c, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_r};
      c_into_msb     = nib_a[3] ^ nib_b[3] ^ nib_s[3];
      ovfl_nx        = c_into_msb ^ nib_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= '0;
         b_r       <= '0;
         carry_r   <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         ovfl      <= 1'b0;
      end else if (!flush) begin
         if (accept) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub;
            cnt     <= '0;
         end else if (state == RUN) begin
            sum[{cnt, 2'b00} +: 4] <= nib_s;
            carry_r                <= nib_c;
            cnt                    <= cnt + 1'b1;
            if (last) begin
               carry_out <= nib_c;
               ovfl      <= ovfl_nx;
`ifdef ADDSUB_SEQ_SAT_EN
               // overflow implies the true result has A's sign
               if (ovfl_nx)
                  sum <= a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl (WIDTH=16): vector table, corner sequences, random vs model.
module tb_addsub_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, sub, flush, out_valid, out_ready;
   logic        carry_out, ovfl, busy;
   logic [15:0] a, b, sum;
   int          n_chk = 0, n_pass = 0;

   addsub_seq_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .ovfl(ovfl),
      .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] va, vb;
      logic        vsub;
      logic [15:0] es;
      logic        eco, eov;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, got, exp);
   endtask

   // signed-integer reference: overflow when the true sum leaves the 16-bit range
   task automatic ref_op(input logic [15:0] ra, input logic [15:0] rb, input logic rsub,
                         output logic [15:0] rs, output logic rco, output logic rov);
      int sa, sb, r;
      logic [16:0] u;
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      r  = rsub ? sa - sb : sa + sb;
      u  = rsub ? ({1'b0, ra} + 17'h10000 - {1'b0, rb}) : ({1'b0, ra} + {1'b0, rb});
      rs  = u[15:0];
      rco = u[16];
      rov = (r > 32767) || (r < -32768);
`ifdef ADDSUB_SEQ_SAT_EN
      if (rov) rs = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                         input int rdly, output logic [15:0] rs, output logic rco,
                         output logic rov, output int lat);
      int g;
      g = 0;
      while (!in_ready && g < 50) begin @(negedge clk); g++; end
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
      rs = sum; rco = carry_out; rov = ovfl;
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         chk("hold_sum", {16'h0, sum}, {16'h0, rs});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("ovld_drop", {31'h0, out_valid}, 32'h0);
   endtask

   logic [15:0] gs, es, hs;
   logic        gco, gov, eco, eov;
   int          lat;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      a = '0; b = '0; sub = 1'b0;
      @(negedge clk);
      chk("rst_state", {12'h0, in_ready, out_valid, busy, carry_out},
          {12'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      chk("rst_sum", {15'h0, ovfl, sum}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
`ifdef ADDSUB_SEQ_SAT_EN
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      tbl[2] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1};
      tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
      tbl[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[6] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};

      foreach (tbl[i]) begin
         run_op(tbl[i].va, tbl[i].vb, tbl[i].vsub, 0, gs, gco, gov, lat);
         chk("vec_lat", lat, 4);
         chk("vec_sum", {16'h0, gs}, {16'h0, tbl[i].es});
         chk("vec_co", {31'h0, gco}, {31'h0, tbl[i].eco});
         chk("vec_ov", {31'h0, gov}, {31'h0, tbl[i].eov});
      end

      // back-pressure: DONE held 3 cycles with a new operation waiting
      a = 16'h0100; b = 16'h0023; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      a = 16'h4000; b = 16'h0FFF; sub = 1'b1;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
      chk("bp_lat", lat, 4);
      hs = sum;
      for (int i = 0; i < 3; i++) begin
         chk("bp_sum", {16'h0, sum}, 32'h0123);
         chk("bp_rdy", {30'h0, in_ready, out_valid}, 32'h1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle", {30'h0, in_ready, out_valid}, 32'h2);
      chk("bp_sum_kept", {16'h0, sum}, {16'h0, hs});
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
      chk("bp2_lat", lat, 4);
      chk("bp2_sum", {16'h0, sum}, 32'h3001);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;

      // reset in 2nd RUN cycle after a result with carry_out and ovfl set
      run_op(16'h8000, 16'h0001, 1'b1, 0, gs, gco, gov, lat);
      a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_rst_ctl", {28'h0, in_ready, out_valid, busy, carry_out}, 32'h8);
      chk("abort_rst_dat", {15'h0, ovfl, sum}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // flush in 2nd RUN cycle; registered results stay untouched
      run_op(16'h8000, 16'h0001, 1'b1, 0, gs, gco, gov, lat);
      a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      chk("flush_idle", {29'h0, in_ready, out_valid, busy}, 32'h4);
      chk("flush_flags", {30'h0, carry_out, ovfl}, 32'h3);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         chk("flush_no_ovld", seen, 0);
      end

      // random operations against the model
      for (int i = 0; i < 200; i++) begin
         logic [15:0] ra, rb;
         logic        rsub;
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rsub = 1'($urandom_range(0, 1));
         ref_op(ra, rb, rsub, es, eco, eov);
         run_op(ra, rb, rsub, int'($urandom_range(0, 3)), gs, gco, gov, lat);
         chk("rnd_lat", lat, 4);
         chk("rnd_sum", {16'h0, gs}, {16'h0, es});
         chk("rnd_co", {31'h0, gco}, {31'h0, eco});
         chk("rnd_ov", {31'h0, gov}, {31'h0, eov});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
